// File: rtl/ni_global.sv
// rtl/ni_global.sv - shared network-interface helpers for flit geometry.
package ni_global;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic bit is_merge(input int link_w, input int hdr_full,
                                  input int addr_w, input int data_w);
    return (hdr_full + addr_w + data_w) <= link_w;
  endfunction

  // Address flits including the head; zero when address and first beat share the head.
  function automatic int addr_pen(input int link_w, input int hdr_full, input int hdr_small,
                                  input int addr_w, input int data_w);
    if (is_merge(link_w, hdr_full, addr_w, data_w)) return 0;
    if (addr_w <= link_w - hdr_full) return 1;
    return 1 + ceil_div(addr_w - (link_w - hdr_full), link_w - hdr_small);
  endfunction

  function automatic int flits_per_beat(input int link_w, input int hdr_full, input int hdr_small,
                                        input int addr_w, input int data_w);
    if (is_merge(link_w, hdr_full, addr_w, data_w)) return 1;
    return ceil_div(data_w, link_w - hdr_small);
  endfunction

  function automatic int pad_bits(input int link_w, input int used_w);
    return (used_w >= link_w) ? 0 : link_w - used_w;
  endfunction

endpackage

// File: rtl/ni_flit_slicer.sv
// rtl/ni_flit_slicer.sv - picks chunk N of a payload and places it above a header.
module ni_flit_slicer #(
  parameter int LINK_WIDTH = 64,
  parameter int PAYLOAD_W  = 37,
  parameter int HDR_W      = 4
) (
  input  logic [PAYLOAD_W-1:0]  payload,
  input  logic [7:0]            chunk_idx,
  input  logic [HDR_W-1:0]      hdr,
  output logic [LINK_WIDTH-1:0] flit
);

  localparam int CHUNK_W = LINK_WIDTH - HDR_W;
  localparam int EXT_W   = PAYLOAD_W + CHUNK_W;

  logic [EXT_W-1:0] ext;

  // Zero extension guarantees the last chunk is zero-padded in its MSBs.
  always_comb begin
    ext  = EXT_W'(payload);
    flit = {CHUNK_W'(ext >> (32'(chunk_idx) * CHUNK_W)), hdr};
  end

endmodule

// File: rtl/ni_wr_flit_packer.sv
// rtl/ni_wr_flit_packer.sv - packs one AXI write burst (AW + W beats) into link flits.
module ni_wr_flit_packer
  import ni_global::*;
#(
  parameter int LINK_WIDTH = 64,
  parameter int ADDR_W     = 61,
  parameter int DATA_W     = 37,
  parameter int HDR_FULL   = 16,
  parameter int HDR_SMALL  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [ADDR_W-1:0]     aw_payload,
  input  logic [7:0]            aw_len,
  input  logic [HDR_FULL-1:0]   aw_hdr,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_W-1:0]     w_payload,
  input  logic                  w_last,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic [LINK_WIDTH-1:0] flit_data,
  output logic                  flit_head,
  output logic                  flit_tail,
  output logic                  err_wlast
);

  localparam bit MERGE     = is_merge(LINK_WIDTH, HDR_FULL, ADDR_W, DATA_W);
  localparam int ADDR_PEN  = addr_pen(LINK_WIDTH, HDR_FULL, HDR_SMALL, ADDR_W, DATA_W);
  localparam int FPD       = flits_per_beat(LINK_WIDTH, HDR_FULL, HDR_SMALL, ADDR_W, DATA_W);
  localparam int MERGE_PAD = pad_bits(LINK_WIDTH, HDR_FULL + ADDR_W + DATA_W);
  localparam int HEAD_BITS = LINK_WIDTH - HDR_FULL;
  localparam int REST_W    = ADDR_W + LINK_WIDTH;

  if (LINK_WIDTH <= HDR_FULL) begin : g_bad_link
    $error("ni_wr_flit_packer: LINK_WIDTH must exceed HDR_FULL");
  end
  if (MERGE && (DATA_W + HDR_SMALL > LINK_WIDTH)) begin : g_bad_merge
    $error("ni_wr_flit_packer: a beat plus small header does not fit a flit");
  end

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                state, state_nx;
  logic [ADDR_W-1:0]     addr_r;
  logic [7:0]            len_r;
  logic [HDR_FULL-1:0]   hdr_r;
  logic [DATA_W-1:0]     buf_data;
  logic                  buf_full;
  logic [7:0]            addr_idx;
  logic [7:0]            chunk_idx;
  logic [7:0]            beat_cnt;

  logic [LINK_WIDTH-1:0] head_flit, addr_flit, data_flit, merged_flit;
  logic                  aw_fire, w_fire, flit_fire;
  logic                  last_addr, last_chunk, last_beat;

  assign aw_ready   = (state == S_IDLE);
  assign w_ready    = (state == S_DATA) && !buf_full;
  assign aw_fire    = aw_valid && aw_ready;
  assign w_fire     = w_valid && w_ready;
  assign flit_fire  = flit_valid && flit_ready;
  assign last_addr  = (addr_idx == 8'(ADDR_PEN - 1));
  assign last_chunk = (chunk_idx == 8'(FPD - 1));
  assign last_beat  = (beat_cnt == len_r);

  ni_flit_slicer #(.LINK_WIDTH(LINK_WIDTH), .PAYLOAD_W(ADDR_W), .HDR_W(HDR_FULL)) u_head_slicer (
    .payload   (addr_r),
    .chunk_idx (8'd0),
    .hdr       (hdr_r),
    .flit      (head_flit)
  );

  // Body address flits continue where the head flit's address bits stopped.
  ni_flit_slicer #(.LINK_WIDTH(LINK_WIDTH), .PAYLOAD_W(REST_W), .HDR_W(HDR_SMALL)) u_addr_slicer (
    .payload   (REST_W'(addr_r) >> HEAD_BITS),
    .chunk_idx (addr_idx - 8'd1),
    .hdr       (hdr_r[HDR_SMALL-1:0]),
    .flit      (addr_flit)
  );

  ni_flit_slicer #(.LINK_WIDTH(LINK_WIDTH), .PAYLOAD_W(DATA_W), .HDR_W(HDR_SMALL)) u_data_slicer (
    .payload   (buf_data),
    .chunk_idx (chunk_idx),
    .hdr       (hdr_r[HDR_SMALL-1:0]),
    .flit      (data_flit)
  );

  if (MERGE) begin : g_merge
    if (MERGE_PAD > 0) begin : g_pad
      assign merged_flit = {{MERGE_PAD{1'b0}}, buf_data, addr_r, hdr_r};
    end else begin : g_nopad
      assign merged_flit = {buf_data, addr_r, hdr_r};
    end
  end else begin : g_split
    assign merged_flit = '0;
  end

  always_comb begin
    state_nx   = state;
    flit_valid = 1'b0;
    flit_head  = 1'b0;
    flit_tail  = 1'b0;
    flit_data  = '0;
    case (state)
      S_IDLE: begin
        if (aw_valid) state_nx = MERGE ? S_DATA : S_ADDR;
      end
      S_ADDR: begin
        flit_valid = 1'b1;
        flit_head  = (addr_idx == 8'd0);
        flit_data  = (addr_idx == 8'd0) ? head_flit : addr_flit;
        if (flit_ready && last_addr) state_nx = S_DATA;
      end
      S_DATA: begin
        if (buf_full) begin
          flit_valid = 1'b1;
          flit_head  = MERGE && (beat_cnt == 8'd0);
          flit_tail  = last_beat && last_chunk;
          flit_data  = (MERGE && (beat_cnt == 8'd0)) ? merged_flit : data_flit;
          if (flit_ready && last_beat && last_chunk) state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_r    <= '0;
      len_r     <= '0;
      hdr_r     <= '0;
      buf_data  <= '0;
      buf_full  <= 1'b0;
      addr_idx  <= '0;
      chunk_idx <= '0;
      beat_cnt  <= '0;
      err_wlast <= 1'b0;
    end else begin
      state     <= state_nx;
      // Beat count is governed by aw_len alone; w_last is only cross-checked.
      err_wlast <= w_fire && (w_last != last_beat);
      if (aw_fire) begin
        addr_r    <= aw_payload;
        len_r     <= aw_len;
        hdr_r     <= aw_hdr;
        addr_idx  <= '0;
        chunk_idx <= '0;
        beat_cnt  <= '0;
      end
      if ((state == S_ADDR) && flit_fire) begin
        addr_idx <= last_addr ? 8'd0 : addr_idx + 8'd1;
      end
      if (w_fire) begin
        buf_data <= w_payload;
        buf_full <= 1'b1;
      end
      if ((state == S_DATA) && flit_fire) begin
        if (last_chunk) begin
          buf_full  <= 1'b0;
          chunk_idx <= '0;
          beat_cnt  <= last_beat ? 8'd0 : beat_cnt + 8'd1;
        end else begin
          chunk_idx <= chunk_idx + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ni_wr_flit_packer.sv
// tb/tb_ni_wr_flit_packer.sv - directed bench over 64/128/32-bit link configurations.
module tb_ni_wr_flit_packer;

  localparam int AW = 61;
  localparam int DW = 37;
  localparam int HF = 16;
  localparam int HS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    sel = 2'd0;
  logic          aw_valid = 1'b0, w_valid = 1'b0, w_last = 1'b0, flit_ready = 1'b0;
  logic [AW-1:0] aw_payload = '0;
  logic [7:0]    aw_len = '0;
  logic [HF-1:0] aw_hdr = '0;
  logic [DW-1:0] w_payload = '0;

  logic [2:0]    aw_ready_v, w_ready_v, fv_v, fh_v, ft_v, err_v;
  logic [63:0]   fd_64;
  logic [127:0]  fd_128;
  logic [31:0]   fd_32;

  logic          aw_ready_s, w_ready_s, fv_s, fh_s, ft_s, err_s;
  logic [127:0]  fd_s;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0]  exp_q[$];
  logic [DW-1:0] beats[$];

  ni_wr_flit_packer #(.LINK_WIDTH(64)) u_l64 (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid && (sel == 2'd0)), .aw_ready(aw_ready_v[0]),
    .aw_payload(aw_payload), .aw_len(aw_len), .aw_hdr(aw_hdr),
    .w_valid(w_valid && (sel == 2'd0)), .w_ready(w_ready_v[0]),
    .w_payload(w_payload), .w_last(w_last),
    .flit_valid(fv_v[0]), .flit_ready(flit_ready && (sel == 2'd0)),
    .flit_data(fd_64), .flit_head(fh_v[0]), .flit_tail(ft_v[0]), .err_wlast(err_v[0])
  );

  ni_wr_flit_packer #(.LINK_WIDTH(128)) u_l128 (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid && (sel == 2'd1)), .aw_ready(aw_ready_v[1]),
    .aw_payload(aw_payload), .aw_len(aw_len), .aw_hdr(aw_hdr),
    .w_valid(w_valid && (sel == 2'd1)), .w_ready(w_ready_v[1]),
    .w_payload(w_payload), .w_last(w_last),
    .flit_valid(fv_v[1]), .flit_ready(flit_ready && (sel == 2'd1)),
    .flit_data(fd_128), .flit_head(fh_v[1]), .flit_tail(ft_v[1]), .err_wlast(err_v[1])
  );

  ni_wr_flit_packer #(.LINK_WIDTH(32)) u_l32 (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid && (sel == 2'd2)), .aw_ready(aw_ready_v[2]),
    .aw_payload(aw_payload), .aw_len(aw_len), .aw_hdr(aw_hdr),
    .w_valid(w_valid && (sel == 2'd2)), .w_ready(w_ready_v[2]),
    .w_payload(w_payload), .w_last(w_last),
    .flit_valid(fv_v[2]), .flit_ready(flit_ready && (sel == 2'd2)),
    .flit_data(fd_32), .flit_head(fh_v[2]), .flit_tail(ft_v[2]), .err_wlast(err_v[2])
  );

  always_comb begin
    aw_ready_s = aw_ready_v[sel];
    w_ready_s  = w_ready_v[sel];
    fv_s       = fv_v[sel];
    fh_s       = fh_v[sel];
    ft_s       = ft_v[sel];
    err_s      = err_v[sel];
    case (sel)
      2'd0:    fd_s = 128'(fd_64);
      2'd1:    fd_s = fd_128;
      default: fd_s = 128'(fd_32);
    endcase
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_aw_ready"}, 128'(aw_ready_s), 128'(1));
    check({tag, "_w_ready"},  128'(w_ready_s),  128'(0));
    check({tag, "_fv"},       128'(fv_s),       128'(0));
    check({tag, "_fhead"},    128'(fh_s),       128'(0));
    check({tag, "_ftail"},    128'(ft_s),       128'(0));
    check({tag, "_err"},      128'(err_s),      128'(0));
    check({tag, "_fdata"},    fd_s,             128'(0));
  endtask

  // Hand-derived flit layouts for each link width.
  function automatic void build_exp(input logic [1:0] s, input logic [AW-1:0] a,
                                    input logic [HF-1:0] h, input int len);
    logic [HS-1:0] hs;
    logic [DW-1:0] bt;
    hs = h[HS-1:0];
    exp_q.delete();
    case (s)
      2'd0: begin
        exp_q.push_back(128'({a[47:0], h}));
        exp_q.push_back(128'({a[60:48], hs}));
        for (int b = 0; b <= len; b++) begin
          bt = beats[b];
          exp_q.push_back(128'({bt, hs}));
        end
      end
      2'd1: begin
        for (int b = 0; b <= len; b++) begin
          bt = beats[b];
          if (b == 0) exp_q.push_back(128'({bt, a, h}));
          else        exp_q.push_back(128'({bt, hs}));
        end
      end
      default: begin
        exp_q.push_back(128'({a[15:0], h}));
        exp_q.push_back(128'({a[43:16], hs}));
        exp_q.push_back(128'({a[60:44], hs}));
        for (int b = 0; b <= len; b++) begin
          bt = beats[b];
          exp_q.push_back(128'({bt[27:0], hs}));
          exp_q.push_back(128'({bt[36:28], hs}));
        end
      end
    endcase
  endfunction

  task automatic run_packet(input string name, input logic [1:0] s, input int len,
                            input int bad_beat, input int stall, input int abort_at,
                            input logic [AW-1:0] a, input logic [HF-1:0] h,
                            input logic [DW-1:0] bseed);
    logic [127:0] got_d[$];
    logic         got_h[$], got_t[$];
    int           errs, viol, unstable, tmo, t, tails;
    bit           done, aborted;
    errs = 0; viol = 0; unstable = 0; tmo = 0; tails = 0;
    done = 1'b0; aborted = 1'b0;
    sel = s;
    beats.delete();
    for (int b = 0; b <= len; b++) beats.push_back(bseed + DW'(b) * 37'h0_1357_9BDF);
    build_exp(s, a, h, len);

    @(negedge clk);
    aw_payload = a; aw_hdr = h; aw_len = 8'(len); aw_valid = 1'b1;
    t = 0;
    while (!aw_ready_s && t < 50) begin @(negedge clk); t++; end
    if (!aw_ready_s) tmo++;
    @(posedge clk); #1;
    aw_valid = 1'b0;

    fork
      begin : drv
        int wt;
        for (int b = 0; b <= len && !aborted; b++) begin
          @(negedge clk);
          w_valid = 1'b1; w_payload = beats[b]; w_last = (b == len) || (b == bad_beat);
          wt = 0;
          while (!w_ready_s && !aborted && wt < 500) begin @(negedge clk); wt++; end
          if (aborted) break;
          if (!w_ready_s) begin tmo++; break; end
          @(posedge clk); #1;
          w_valid = 1'b0;
        end
        w_valid = 1'b0;
      end
      begin : mon
        int mt, idx;
        bit fin;
        logic [127:0] hold;
        logic hh, tt;
        mt = 0; idx = 0; fin = 1'b0;
        flit_ready = (stall == 0);
        while (!fin && mt < 2000) begin
          @(negedge clk); mt++;
          if (fv_s) begin
            if (idx == abort_at) begin
              rst_n = 1'b0; #1;
              check_reset_outputs({name, "_abort"});
              aborted = 1'b1; fin = 1'b1;
            end else begin
              hold = fd_s; hh = fh_s; tt = ft_s;
              if (w_ready_s) viol++;
              for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                if (fd_s !== hold || fv_s !== 1'b1 || fh_s !== hh || ft_s !== tt) unstable++;
                if (w_ready_s) viol++;
              end
              if (tt) check({name, "_tail_busy"}, 128'(aw_ready_s), 128'(0));
              flit_ready = 1'b1;
              @(posedge clk); #1;
              got_d.push_back(hold); got_h.push_back(hh); got_t.push_back(tt);
              if (stall != 0) flit_ready = 1'b0;
              if (tt) begin
                check({name, "_bubble_idle"}, 128'(aw_ready_s), 128'(1));
                fin = 1'b1;
              end
              idx++;
            end
          end
        end
        if (!fin) tmo++;
        flit_ready = 1'b0;
        repeat (3) @(negedge clk);
        done = 1'b1;
      end
      begin : errmon
        while (!done) begin
          @(negedge clk);
          if (err_s) errs++;
        end
      end
    join

    w_valid = 1'b0;
    if (abort_at >= 0) begin
      @(negedge clk);
      rst_n = 1'b1;
      foreach (got_t[i]) if (got_t[i]) tails++;
      check({name, "_abort_flits"}, 128'(got_d.size()), 128'(abort_at));
      check({name, "_abort_tails"}, 128'(tails), 128'(0));
      check({name, "_abort_err"},   128'(errs), 128'(0));
    end else begin
      check({name, "_nflits"}, 128'(got_d.size()), 128'(exp_q.size()));
      for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
        check($sformatf("%s_data%0d", name, i), got_d[i], exp_q[i]);
        check($sformatf("%s_head%0d", name, i), 128'(got_h[i]), 128'(i == 0));
        check($sformatf("%s_tail%0d", name, i), 128'(got_t[i]), 128'(i == exp_q.size() - 1));
      end
      check({name, "_err"},      128'(errs), 128'((bad_beat >= 0) ? 1 : 0));
      check({name, "_wr_full"},  128'(viol), 128'(0));
      check({name, "_stable"},   128'(unstable), 128'(0));
    end
    check({name, "_timeout"}, 128'(tmo), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    sel = 2'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_packet("l64_len3",    2'd0, 3, -1, 0, -1, 61'h0ABC_DEF0_1234_5678, 16'hA5C3, 37'h1_2345_6789);
    run_packet("l64_stall",   2'd0, 3, -1, 5, -1, 61'h1F0E_D0C0_B0A0_9080, 16'h7E19, 37'h0_F0F0_F0F0);
    run_packet("l64_wlast",   2'd0, 1,  0, 0, -1, 61'h0000_1111_2222_3333, 16'h4C2B, 37'h1_FFFF_0000);
    run_packet("l128_len3",   2'd1, 3, -1, 0, -1, 61'h1555_AAAA_5555_AAAA, 16'hBEEF, 37'h0_0BAD_F00D);
    run_packet("l128_single", 2'd1, 0, -1, 0, -1, 61'h1234_5678_9ABC_DEF0, 16'h0F0F, 37'h1_CAFE_BABE);
    run_packet("l128_stall",  2'd1, 2, -1, 5, -1, 61'h0FED_CBA9_8765_4321, 16'hC001, 37'h0_1111_2222);
    run_packet("l32_len0",    2'd2, 0, -1, 0, -1, 61'h1ACE_0123_4567_89AB, 16'h3D5E, 37'h1_5A5A_A5A5);
    run_packet("l32_stall",   2'd2, 1, -1, 2, -1, 61'h0246_8ACE_1357_9BDF, 16'h9008, 37'h0_7777_8888);
    run_packet("l64_abort",   2'd0, 3, -1, 0,  2, 61'h1111_2222_3333_4444, 16'h6A6A, 37'h0_ABCD_EF01);
    run_packet("l64_after",   2'd0, 0, -1, 0, -1, 61'h0DEA_DBEE_F000_1234, 16'h2468, 37'h1_0000_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
